nibble_add_sequencer: RTL and testbench
=======================================

# nibble_add_sequencer

Controller that time-shares one 4-bit `ripple_adder` (operands A and B, 5-bit result X, no carry-in) to add two wide unsigned operands one nibble at a time. It accepts a start request and latches the operands. Each nibble is resolved in two adder passes: operand add, then carry add. The block returns the full-width sum with a one-cycle `done` pulse. It sits between a requesting datapath and a single external `ripple_adder` instance, which it drives combinationally.

## Interface
- `NIB`, default 4: number of nibbles per operand. Operand width is 4*NIB bits; sum width is 4*NIB+1 bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `op_a`  in  4*NIB  operand A; sampled on an accepted start.
- `op_b`  in  4*NIB  operand B; sampled on an accepted start.
- `ready`  out  1  high only in IDLE.
- `busy`  out  1  high in ADD and CARRY.
- `done`  out  1  one-cycle pulse; `sum` is valid and updated in this cycle.
- `sum`  out  4*NIB+1  result, with the final carry in the MSB; holds its value until the next `done`.
- `add_a`  out  4  to ripple_adder A.
- `add_b`  out  4  to ripple_adder B.
- `add_x`  in  5  from ripple_adder X, combinational: X = A + B.

## Operation
- **States:** IDLE, ADD, CARRY, DONE. Internal registers:
  - nibble index `k` (0..NIB-1)
  - carry bit `c`
  - pass-1 result `p[4:0]`
  - latched operands
  - accumulating result
- **IDLE:**
  - `add_a`=0, `add_b`=0.
  - On `start`=1: latch `op_a`/`op_b`, set k=0, c=0, go to ADD.
- **ADD:**
  - `add_a` = A[4k+3:4k], `add_b` = B[4k+3:4k].
  - Register p = `add_x`, go to CARRY.
- **CARRY:**
  - `add_a` = p[3:0], `add_b` = {3'b000, c}.
  - Write result nibble k = `add_x`[3:0].
  - Update c = p[4] | `add_x`[4]. Both bits are never 1 together.
  - If k=NIB-1, go to DONE. Otherwise k=k+1 and go to ADD.
- **CARRY pass is unconditional:** it runs even when c=0, giving a fixed latency.
- **DONE:**
  - `sum` = {c, result}, `done`=1, `add_a`/`add_b`=0.
  - Go to IDLE next cycle.
- **Start while not in IDLE** (busy or DONE): ignored, not queued.
- **Operand changes after acceptance:** `op_a`/`op_b` changes have no effect on the running add.
- **Reset** (`rst_n`=0 on any edge, including mid-operation):
  - Go to IDLE; abandon the partial result.
  - `ready`=1, `busy`=0, `done`=0, `sum`=0, `add_a`=`add_b`=0, k=0, c=0.
- **Arithmetic:** unsigned, modulo-free. `sum` = `op_a` + `op_b` exactly, in 4*NIB+1 bits.

## Timing
- Start accepted at edge 0 (cycle 0, IDLE).
- ADD for nibble k occupies cycle 2k+1; CARRY for nibble k occupies cycle 2k+2.
- `done` is high in cycle 2*NIB+1 (cycle 9 for NIB=4), and `sum` is valid in that same cycle.
- `ready` returns high in cycle 2*NIB+2. The earliest next accepted start is that cycle; throughput is one add per 2*NIB+2 cycles.
- `add_a`/`add_b` are pure functions of state and registers, and `add_x` is sampled in the same cycle. The adder lies on a single-cycle combinational path.
- `ready`, `busy` and `done` are mutually exclusive, and exactly one is high in every cycle after reset.

## Test plan
- **Basic add:** reset, then start with A=0x1234, B=0x4321. Required: `done` exactly 9 cycles after start, `sum`=0x05555, `busy` high for cycles 1–8.
- **Full carry ripple:** A=0xFFFF, B=0x0001. Required: `sum`=0x10000. The bench checks that every CARRY pass drives `add_b`=0001 for k≥1.
- **Maximum operands:** A=0xFFFF, B=0xFFFF. Required: `sum`=0x1FFFE. Also run A=0, B=0, which must give `sum`=0x00000.
- **Start while busy:** pulse start with A=0x0001, B=0x0001, then pulse start again in cycle 3 with A=0xAAAA, B=0x5555. Required: the second request is ignored, exactly one `done` appears, and `sum`=0x00002.
- **Reset mid-operation:** assert `rst_n`=0 in cycle 5 of an add. Required on the next edge: `ready`=1, `busy`=0, `sum`=0, no `done` pulse. A subsequent 0x0F0F+0x00F1 must give 0x01000.
- **Back-to-back and exhaustive:** random pairs issued on the first `ready` cycle, plus (NIB=1) all 256 pairs of A, B in 0..15. Required: every result compared against A+B with `!==`, the bench stops on the first mismatch, and no idle-cycle gap beyond the spec.

Source files
------------

// File: rtl/nibble_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : nibble_add_sequencer
// Description : Adds two 4*NIB-bit unsigned operands one nibble at a time by
//               time-sharing a single external 4-bit ripple adder. Each
//               nibble takes an operand pass then a carry pass; the full
//               4*NIB+1 bit sum is presented with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_add_sequencer #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4*NIB-1:0] op_a,
    input  logic [4*NIB-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [4*NIB:0]   sum,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    input  logic [4:0]       add_x
);

    localparam int W  = 4 * NIB;
    localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] C_K_LAST = KW'(NIB - 1);
    localparam logic [KW-1:0] C_K_ONE  = KW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_CARRY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [W-1:0]    r_op_a;
    logic [W-1:0]    r_op_b;
    logic [W-1:0]    r_res;
    logic [W:0]      r_sum;
    logic [KW-1:0]   r_k;
    logic            r_c;
    logic [4:0]      r_p;

    logic [W-1:0]    w_a_shift;
    logic [W-1:0]    w_b_shift;
    logic [3:0]      w_add_a;
    logic [3:0]      w_add_b;
    logic            w_c_nxt;
    logic            w_k_last;
    logic [W-1:0]    w_res_nxt;

    // Nibble k of each latched operand, brought down to bits [3:0].
    assign w_a_shift = r_op_a >> {r_k, 2'b00};
    assign w_b_shift = r_op_b >> {r_k, 2'b00};

    // Carry out of nibble k: at most one of the two passes can carry.
    assign w_c_nxt  = r_p[4] | add_x[4];
    assign w_k_last = (r_k == C_K_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and adder operand steering.
    always_comb begin
        w_state_nxt = r_state;
        w_add_a     = 4'd0;
        w_add_b     = 4'd0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                w_add_a     = w_a_shift[3:0];
                w_add_b     = w_b_shift[3:0];
                w_state_nxt = S_CARRY;
            end
            S_CARRY: begin
                // Runs even when the incoming carry is zero so latency is fixed.
                w_add_a     = r_p[3:0];
                w_add_b     = {3'b000, r_c};
                w_state_nxt = w_k_last ? S_DONE : S_ADD;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Accumulated result with nibble k replaced by the carry-pass output.
    always_comb begin
        w_res_nxt = r_res;
        for (int i = 0; i < NIB; i++) begin
            if (r_k == KW'(i)) begin
                w_res_nxt[4*i +: 4] = add_x[3:0];
            end
        end
    end

    // Datapath registers: operand latch, pass-1 result, carry, index, sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_a <= '0;
            r_op_b <= '0;
            r_res  <= '0;
            r_sum  <= '0;
            r_k    <= '0;
            r_c    <= 1'b0;
            r_p    <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op_a <= op_a;
                        r_op_b <= op_b;
                        r_res  <= '0;
                        r_k    <= '0;
                        r_c    <= 1'b0;
                    end
                end
                S_ADD: begin
                    r_p <= add_x;
                end
                S_CARRY: begin
                    r_res <= w_res_nxt;
                    r_c   <= w_c_nxt;
                    if (w_k_last) begin
                        // Load the sum now so it is already valid while done is high.
                        r_sum <= {w_c_nxt, w_res_nxt};
                    end else begin
                        r_k <= r_k + C_K_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready = (r_state == S_IDLE);
    assign busy  = (r_state == S_ADD) || (r_state == S_CARRY);
    assign done  = (r_state == S_DONE);
    assign sum   = r_sum;
    assign add_a = w_add_a;
    assign add_b = w_add_b;

endmodule
`default_nettype wire

// File: tb/tb_nibble_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_add_sequencer
// Description : Directed, table-driven bench for nibble_add_sequencer, with a
//               behavioural ripple adder; NIB=4 and NIB=1 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_add_sequencer;

    logic        clk;
    logic        rst_n;

    // NIB = 4 instance
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [16:0] sum;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic [4:0]  add_x;

    // NIB = 1 instance
    logic        s1_start;
    logic [3:0]  s1_a;
    logic [3:0]  s1_b;
    logic        s1_ready;
    logic        s1_busy;
    logic        s1_done;
    logic [4:0]  s1_sum;
    logic [3:0]  s1_add_a;
    logic [3:0]  s1_add_b;
    logic [4:0]  s1_add_x;

    int checks;
    int errors;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[8];

    // External ripple adders.
    assign add_x    = {1'b0, add_a} + {1'b0, add_b};
    assign s1_add_x = {1'b0, s1_add_a} + {1'b0, s1_add_b};

    nibble_add_sequencer #(.NIB(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .add_a (add_a),
        .add_b (add_b),
        .add_x (add_x)
    );

    nibble_add_sequencer #(.NIB(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s1_start),
        .op_a  (s1_a),
        .op_b  (s1_b),
        .ready (s1_ready),
        .busy  (s1_busy),
        .done  (s1_done),
        .sum   (s1_sum),
        .add_a (s1_add_a),
        .add_b (s1_add_b),
        .add_x (s1_add_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Carry entering nibble k of a+b.
    function automatic logic carry_in(input logic [15:0] a, input logic [15:0] b, input int k);
        logic [31:0] m;
        logic [31:0] s;
        m = (32'd1 << (4 * k)) - 32'd1;
        s = ({16'd0, a} & m) + ({16'd0, b} & m);
        return s[4*k];
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] v, input int k);
        logic [15:0] t;
        t = v >> (4 * k);
        return t[3:0];
    endfunction

    // One full add on the NIB=4 instance, entered in a cycle where ready is high.
    // poke: re-request start with other operands in cycle 3.
    task automatic run_add(input logic [15:0] a, input logic [15:0] b,
                           input logic [16:0] exp, input bit poke);
        int n;
        int k;
        bit got;
        logic [4:0] ps;
        chk("ready_before_start", 32'(ready), 32'd1);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        n     = 0;
        got   = 1'b0;
        while (!got && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                start = 1'b0;
                op_a  = ~a;
                op_b  = ~b;
            end
            if (poke && n == 3) begin
                start = 1'b1;
                op_a  = 16'hAAAA;
                op_b  = 16'h5555;
            end
            if (poke && n == 4) start = 1'b0;
            if (done) begin
                got = 1'b1;
            end else begin
                chk("busy_in_op", 32'(busy), 32'd1);
                if (n % 2 == 1) begin
                    k = (n - 1) / 2;
                    chk("add_a_pass1", 32'(add_a), 32'(nib(a, k)));
                    chk("add_b_pass1", 32'(add_b), 32'(nib(b, k)));
                end else begin
                    k  = n / 2 - 1;
                    ps = {1'b0, nib(a, k)} + {1'b0, nib(b, k)};
                    chk("add_a_carry", 32'(add_a), 32'(ps[3:0]));
                    chk("add_b_carry", 32'(add_b), 32'({3'b000, carry_in(a, b, k)}));
                end
            end
        end
        chk("done_latency", 32'(n), 32'd9);
        chk("sum", 32'(sum), 32'(exp));
        chk("ready_busy_in_done", 32'({ready, busy}), 32'd0);
        chk("adder_idle_in_done", 32'({add_a, add_b}), 32'd0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("ready_after_done", 32'(ready), 32'd1);
        chk("sum_hold", 32'(sum), 32'(exp));
    endtask

    task automatic run_add1(input logic [3:0] a, input logic [3:0] b);
        int n;
        bit got;
        chk("n1_ready_before", 32'(s1_ready), 32'd1);
        s1_start = 1'b1;
        s1_a     = a;
        s1_b     = b;
        n        = 0;
        got      = 1'b0;
        while (!got && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) s1_start = 1'b0;
            if (s1_done) got = 1'b1;
        end
        chk("n1_latency", 32'(n), 32'd3);
        chk("n1_sum", 32'(s1_sum), 32'({1'b0, a} + {1'b0, b}));
        @(posedge clk);
        #1;
        chk("n1_ready_after", 32'(s1_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int n;

        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op_a     = 16'd0;
        op_b     = 16'd0;
        s1_start = 1'b0;
        s1_a     = 4'd0;
        s1_b     = 4'd0;

        vecs[0] = '{16'h1234, 16'h4321, 17'h05555};
        vecs[1] = '{16'hFFFF, 16'h0001, 17'h10000};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE};
        vecs[3] = '{16'h0000, 16'h0000, 17'h00000};
        vecs[4] = '{16'h8000, 16'h8000, 17'h10000};
        vecs[5] = '{16'hABCD, 16'h1111, 17'h0BCDE};
        vecs[6] = '{16'h00FF, 16'h0F01, 17'h01000};
        vecs[7] = '{16'h7FFF, 16'h0001, 17'h08000};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_adder", 32'({add_a, add_b}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven adds, issued back to back.
        for (int i = 0; i < 8; i++) begin
            run_add(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
        end

        // Start while busy is ignored; exactly one done follows.
        run_add(16'h0001, 16'h0001, 17'h00002, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("no_queued_done", 32'(done), 32'd0);
            chk("no_queued_busy", 32'(busy), 32'd0);
        end

        // Reset in cycle 5 of an add abandons it.
        chk("mid_rst_ready", 32'(ready), 32'd1);
        start = 1'b1;
        op_a  = 16'h1111;
        op_b  = 16'h2222;
        n     = 0;
        while (n < 5) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_adder", 32'({add_a, add_b}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_done", 32'(done), 32'd0);
        run_add(16'h0F0F, 16'h00F1, 17'h01000, 1'b0);

        // Random back-to-back adds; stop on the first error.
        for (int i = 0; i < 24; i++) begin
            if (errors != 0) break;
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_add(ra, rb, {1'b0, ra} + {1'b0, rb}, 1'b0);
        end

        // Exhaustive single-nibble adds.
        for (int i = 0; i < 256; i++) begin
            if (errors != 0) break;
            run_add1(4'(i >> 4), 4'(i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
